// File: rtl/mux4_pkg.sv
// Shared definitions for the 4:1 mux scheduler: FSM encoding, channel
// count and select width.
package mux4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        return {{(NUM_CH-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request bit scanning
// ptr, ptr+1, ... modulo four.
module rr_pick4
    import mux4_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  winner,
    output logic              any
);

    logic [SEL_W-1:0] idx;

    // Scan from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        winner = ptr;
        idx    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux4_rr_scheduler.sv
// Round-robin control stage for a 4:1 mux: arbitrates requests, drives sel,
// waits out the settle time, captures y and hands it downstream.
module mux4_rr_scheduler
    import mux4_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic [WIDTH-1:0]  mux_y,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] gnt,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_ptr_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [SEL_W-1:0] pick;
    logic             pick_any;
    logic [3:0]       settle_cnt;
    logic [3:0]       settle_cnt_nxt;
    logic             req_held;
    logic             capture;
    logic             release_out;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (pick),
        .any    (pick_any)
    );

    assign req_held = req[sel];
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        settle_cnt_nxt = settle_cnt;
        rr_ptr_nxt     = rr_ptr;
        capture        = 1'b0;
        release_out    = 1'b0;
        gnt            = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    sel_nxt        = pick;
                    settle_cnt_nxt = SETTLE_INIT;
                    state_nxt      = SETTLE;
                end
            end
            SETTLE: begin
                if (!req_held) begin
                    state_nxt = IDLE;
                end else if (settle_cnt == 4'd0) begin
                    state_nxt = CAPTURE;
                end else begin
                    settle_cnt_nxt = settle_cnt - 4'd1;
                end
            end
            CAPTURE: begin
                if (!req_held) begin
                    state_nxt = IDLE;
                end else begin
                    capture    = 1'b1;
                    gnt        = onehot(sel);
                    rr_ptr_nxt = sel + 2'd1;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    release_out = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A transfer cut short by reset must not be reported as granted.
        if (rst) begin
            gnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            rr_ptr     <= '0;
            settle_cnt <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            rr_ptr     <= rr_ptr_nxt;
            settle_cnt <= settle_cnt_nxt;
            if (capture) begin
                out_data  <= mux_y;
                out_valid <= 1'b1;
            end else if (release_out) begin
                out_valid <= 1'b0;
            end
        end
    end

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_capture : assert property (@(posedge clk) disable iff (rst) (gnt != '0) |-> (state == CAPTURE));

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Bench for mux4_rr_scheduler: two instances (settle 1 and 3) share the stimulus
// and are compared every cycle against a transaction-age model plus literal checks.
module tb_mux4_rr_scheduler;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = 4'b0000;
    logic         out_ready = 1'b1;
    logic [1:0]   sel_a, sel_b;
    logic [3:0]   gnt_a, gnt_b;
    logic [W-1:0] y_a, y_b, data_a, data_b;
    logic         vld_a, vld_b, busy_a, busy_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    // Mux inputs: i0=0001, i1=0010, i2=0011, i3=0100.
    function automatic logic [W-1:0] mux_in(input logic [1:0] s);
        return W'(s) + W'(1);
    endfunction

    assign y_a = mux_in(sel_a);
    assign y_b = mux_in(sel_b);

    mux4_rr_scheduler #(.WIDTH(W), .SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .req(req), .mux_y(y_a), .sel(sel_a), .gnt(gnt_a),
        .out_data(data_a), .out_valid(vld_a), .out_ready(out_ready), .busy(busy_a)
    );

    mux4_rr_scheduler #(.WIDTH(W), .SETTLE_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .req(req), .mux_y(y_b), .sel(sel_b), .gnt(gnt_b),
        .out_data(data_b), .out_valid(vld_b), .out_ready(out_ready), .busy(busy_b)
    );

    // Model: a pending transfer is tracked by its age since the winner was chosen.
    int           s_cyc [2] = '{1, 3};
    bit           m_act [2] = '{1'b0, 1'b0};
    int           m_age [2] = '{0, 0};
    logic [1:0]   m_sel [2] = '{2'd0, 2'd0};
    logic [1:0]   m_ptr [2] = '{2'd0, 2'd0};
    logic [W-1:0] m_data[2] = '{'0, '0};
    bit           m_vld [2] = '{1'b0, 1'b0};

    task automatic model_step(input int i);
        bit found;
        int c;
        if (rst) begin
            m_act[i] = 1'b0; m_age[i] = 0; m_sel[i] = 2'd0;
            m_ptr[i] = 2'd0; m_data[i] = '0; m_vld[i] = 1'b0;
        end else if (m_vld[i]) begin
            if (out_ready) m_vld[i] = 1'b0;
        end else if (m_act[i]) begin
            if (!req[m_sel[i]]) begin
                m_act[i] = 1'b0;
            end else if (m_age[i] == s_cyc[i]) begin
                m_data[i] = mux_in(m_sel[i]);
                m_vld[i]  = 1'b1;
                m_ptr[i]  = 2'((int'(m_sel[i]) + 1) % 4);
                m_act[i]  = 1'b0;
            end else begin
                m_age[i]++;
            end
        end else if (req != 4'b0000) begin
            found = 1'b0;
            for (int j = 0; j < 4; j++) begin
                c = (int'(m_ptr[i]) + j) % 4;
                if (!found && req[c]) begin
                    found    = 1'b1;
                    m_sel[i] = 2'(c);
                end
            end
            m_act[i] = 1'b1;
            m_age[i] = 0;
        end
    endtask

    function automatic logic [3:0] exp_gnt(input int i);
        if (!rst && m_act[i] && m_age[i] == s_cyc[i] && req[m_sel[i]])
            return 4'b0001 << m_sel[i];
        return 4'b0000;
    endfunction

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a.sel",  32'(sel_a),  32'(m_sel[0]));
            check("a.gnt",  32'(gnt_a),  32'(exp_gnt(0)));
            check("a.vld",  32'(vld_a),  32'(m_vld[0]));
            check("a.data", 32'(data_a), 32'(m_data[0]));
            check("a.busy", 32'(busy_a), 32'(m_act[0] || m_vld[0]));
            check("a.ptr",  32'(dut_a.rr_ptr), 32'(m_ptr[0]));
            check("b.sel",  32'(sel_b),  32'(m_sel[1]));
            check("b.gnt",  32'(gnt_b),  32'(exp_gnt(1)));
            check("b.vld",  32'(vld_b),  32'(m_vld[1]));
            check("b.data", 32'(data_b), 32'(m_data[1]));
            check("b.busy", 32'(busy_b), 32'(m_act[1] || m_vld[1]));
            check("b.ptr",  32'(dut_b.rr_ptr), 32'(m_ptr[1]));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int         gcount;
        logic [1:0] pb;
        logic [3:0] eg;

        cyc(2);
        check("rst.sel",  32'(sel_a),  32'd0);
        check("rst.gnt",  32'(gnt_a),  32'd0);
        check("rst.vld",  32'(vld_a),  32'd0);
        check("rst.data", 32'(data_a), 32'd0);
        check("rst.busy", 32'(busy_a), 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Single request on channel 2.
        req = 4'b0100;
        cyc();
        check("single.sel",  32'(sel_a),  32'd2);
        check("single.busy", 32'(busy_a), 32'd1);
        cyc();
        check("single.gnt", 32'(gnt_a), 32'b0100);
        cyc();
        check("single.vld",  32'(vld_a),  32'd1);
        check("single.data", 32'(data_a), 32'b0011);
        check("single.gnt0", 32'(gnt_a),  32'd0);
        check("single.ptr",  32'(dut_a.rr_ptr), 32'd3);
        req = 4'b0000;
        cyc();
        check("single.vld_drop", 32'(vld_a), 32'd0);
        cyc(6);

        // Wrap-around from rr_ptr=3.
        req = 4'b0011;
        cyc();
        check("wrap.sel0", 32'(sel_a), 32'd0);
        cyc();
        check("wrap.gnt0", 32'(gnt_a), 32'b0001);
        cyc();
        check("wrap.data0", 32'(data_a), 32'b0001);
        check("wrap.ptr1",  32'(dut_a.rr_ptr), 32'd1);
        cyc(2);
        check("wrap.sel1", 32'(sel_a), 32'd1);
        cyc();
        check("wrap.gnt1", 32'(gnt_a), 32'b0010);
        cyc();
        check("wrap.data1", 32'(data_a), 32'b0010);
        req = 4'b0000;
        cyc(8);

        // Fairness with all requests held, from a fresh pointer.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("fair.ptr_reset", 32'(dut_a.rr_ptr), 32'd0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cyc(2);
            eg = 4'b0001 << (k % 4);
            check("fair.gnt", 32'(gnt_a), 32'(eg));
            cyc();
            check("fair.data", 32'(data_a), 32'((k % 4) + 1));
            if (k == 4) req = 4'b0000;
            cyc();
        end
        cyc(7);

        // Backpressure on channel 1.
        out_ready = 1'b0;
        req       = 4'b0010;
        gcount    = 0;
        cyc();
        if (gnt_a != 4'b0000) gcount++;
        cyc();
        if (gnt_a != 4'b0000) gcount++;
        check("bp.gnt", 32'(gnt_a), 32'b0010);
        cyc();
        req = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cyc();
            if (gnt_a != 4'b0000) gcount++;
            check("bp.vld",  32'(vld_a),  32'd1);
            check("bp.data", 32'(data_a), 32'b0010);
        end
        out_ready = 1'b1;
        cyc();
        if (gnt_a != 4'b0000) gcount++;
        check("bp.vld_drop", 32'(vld_a),  32'd0);
        check("bp.idle",     32'(busy_a), 32'd0);
        check("bp.gnt_once", 32'(gcount), 32'd1);
        cyc(8);

        // Withdrawn request on the three-cycle-settle instance.
        pb  = m_ptr[1];
        req = 4'b1000;
        cyc();
        check("wd.busy", 32'(busy_b), 32'd1);
        check("wd.sel",  32'(sel_b),  32'd3);
        cyc();
        req = 4'b0000;
        cyc();
        check("wd.idle", 32'(busy_b), 32'd0);
        check("wd.vld",  32'(vld_b),  32'd0);
        check("wd.gnt",  32'(gnt_b),  32'd0);
        check("wd.ptr",  32'(dut_b.rr_ptr), 32'(pb));
        cyc(8);

        // Reset during CAPTURE.
        req = 4'b0100;
        cyc(2);
        check("rmid.gnt_pre", 32'(gnt_a), 32'b0100);
        rst = 1'b1;
        #1;
        check("rmid.gnt_rst", 32'(gnt_a), 32'd0);
        cyc();
        check("rmid.sel",  32'(sel_a),  32'd0);
        check("rmid.gnt",  32'(gnt_a),  32'd0);
        check("rmid.vld",  32'(vld_a),  32'd0);
        check("rmid.data", 32'(data_a), 32'd0);
        check("rmid.busy", 32'(busy_a), 32'd0);
        check("rmid.ptr",  32'(dut_a.rr_ptr), 32'd0);
        rst = 1'b0;
        req = 4'b0000;
        cyc(4);
        check("rmid.no_xfer", 32'(vld_a), 32'd0);
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
